// File: rtl/axi4_wr_burst_gen_if.sv
// ---------------------------------------------------------------------------
// axi4_wr_burst_gen_if
// AXI4 write-channel bundle (AW, W, B) shared by the write burst generator and
// whatever slave model or protocol monitor sits on the same bus.
//   master modport : drives AW/W payload + valids and bready
//   slave  modport : drives awready, wready and the B response
// ---------------------------------------------------------------------------
interface axi4_wr_burst_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    // AW channel
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [ID_W-1:0]     awid;
    // W channel
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    // B channel
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/axi4_wr_burst_gen.sv
// ---------------------------------------------------------------------------
// axi4_wr_burst_gen
// AXI4 write-master stimulus engine. Takes one burst command at a time and
// plays it out as one AW handshake, awlen+1 INCR W beats carrying
// seed, seed+1, ... and one B response, then reports a completion pulse.
// VALID and payload only change on the cycle after a handshake, so every
// burst is protocol-legal.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_*_i/_o      : burst command (addr, len, id, seed) with valid/ready
//   done_valid_o    : one-cycle completion pulse
//   done_resp_o     : captured bresp (SLVERR when the watchdog fires)
//   done_id_err_o   : bid did not match the issued awid
//   axi             : AXI4 AW/W/B channels, master side
//
// Optional build macro AXI4_WR_TIMEOUT_EN: adds a B-response watchdog that
// completes the burst with SLVERR after TO_CYCLES cycles in B without bvalid.
// Without it the block waits in B indefinitely.
// ---------------------------------------------------------------------------
module axi4_wr_burst_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [7:0]        cmd_len_i,
    input  logic [ID_W-1:0]   cmd_id_i,
    input  logic [DATA_W-1:0] cmd_seed_i,
    output logic              done_valid_o,
    output logic [1:0]        done_resp_o,
    output logic              done_id_err_o,
    axi4_wr_burst_gen_if.master axi
);
    localparam logic [2:0] SIZE_C = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] wdata_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              wlast_q;
    logic              bready_q;
    logic              done_valid_q;
    logic [1:0]        done_resp_q;
    logic              done_id_err_q;

`ifdef AXI4_WR_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
`else
    logic to_unused;
    assign to_unused = (TO_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            id_q          <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            bready_q      <= 1'b0;
            done_valid_q  <= 1'b0;
            done_resp_q   <= 2'b00;
            done_id_err_q <= 1'b0;
`ifdef AXI4_WR_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q    <= cmd_addr_i;
                        len_q     <= cmd_len_i;
                        id_q      <= cmd_id_i;
                        wdata_q   <= cmd_seed_i;
                        beat_q    <= '0;
                        awvalid_q <= 1'b1;
                        state_q   <= S_AW;
                    end
                end
                S_AW: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == 8'd0);
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    // wvalid is always high here, so wready alone is a handshake
                    if (axi.wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_B;
`ifdef AXI4_WR_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end else begin
                            // data tracks seed+beat incrementally; the beat
                            // count stops at len, so 256-beat bursts never wrap
                            beat_q  <= beat_q + 8'd1;
                            wdata_q <= wdata_q + DATA_W'(1);
                            wlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                S_B: begin
                    if (axi.bvalid) begin
                        bready_q      <= 1'b0;
                        done_valid_q  <= 1'b1;
                        done_resp_q   <= axi.bresp;
                        done_id_err_q <= (axi.bid != id_q);
                        state_q       <= S_IDLE;
                    end
`ifdef AXI4_WR_TIMEOUT_EN
                    // bvalid in the same cycle takes priority above
                    else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                        bready_q      <= 1'b0;
                        done_valid_q  <= 1'b1;
                        done_resp_q   <= 2'b10;
                        done_id_err_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign done_valid_o  = done_valid_q;
    assign done_resp_o   = done_resp_q;
    assign done_id_err_o = done_id_err_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = SIZE_C;
    assign axi.awburst = 2'b01;
    assign axi.awid    = id_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = '1;
    assign axi.wlast   = wlast_q;
    assign axi.bready  = bready_q;
endmodule

// File: tb/tb_axi4_wr_burst_gen.sv
// ---------------------------------------------------------------------------
// tb_axi4_wr_burst_gen
// Directed + randomized bench for axi4_wr_burst_gen. Each burst is checked
// cycle by cycle against a burst-level model: beat i carries seed+i, wlast
// only on beat len, bready only after the last beat, completion reports bresp
// and the id match (or SLVERR after TO_CYCLES B cycles when the watchdog is
// built in).
// ---------------------------------------------------------------------------
module tb_axi4_wr_burst_gen;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int TO = 16;
`ifdef AXI4_WR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [IW-1:0] cmd_id = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic          done_id_err;

    int n_pass = 0;
    int n_tot  = 0;

    axi4_wr_burst_gen_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

    axi4_wr_burst_gen #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .TO_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .cmd_id_i     (cmd_id),
        .cmd_seed_i   (cmd_seed),
        .done_valid_o (done_valid),
        .done_resp_o  (done_resp),
        .done_id_err_o(done_id_err),
        .axi          (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic bound_fail(input string tag);
        n_tot++;
        $error("FAIL %s observed=bound_expired expected=handshake", tag);
    endtask

    // Play one burst. Inputs change and outputs are sampled at negedge.
    //   aw_dly : cycles awready is held low after awvalid rises
    //   wmode  : 0 always ready, 1 toggling 1,0,1,0, 2 random
    //   b_dly  : B cycles before bvalid is raised
    //   abort  : W beat index at which reset is pulsed (-1 = none)
    task automatic burst(input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id,
                         input logic [DW-1:0] sd, input int aw_dly, input int wmode,
                         input logic [IW-1:0] rbid, input logic [1:0] rresp,
                         input int b_dly, input int abort);
        int n, beat, t, k;
        bit tmo;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_seed = sd;
        axi.awready = (aw_dly == 0);
        @(negedge clk);
        cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_id = IW'($urandom);
        cmd_seed = {$urandom, $urandom};
        chk("cmd_ready_busy", cmd_ready, 0);
        n = 0;
        forever begin
            chk("awvalid", axi.awvalid, 1);
            chk("awaddr", axi.awaddr, a);
            chk("awlen", axi.awlen, l);
            chk("awid", axi.awid, id);
            chk("wvalid_in_aw", axi.wvalid, 0);
            chk("bready_in_aw", axi.bready, 0);
            if (n == 0) begin
                chk("awsize", axi.awsize, 3);
                chk("awburst", axi.awburst, 1);
                chk("wstrb", axi.wstrb, 8'hff);
            end
            axi.awready = (n >= aw_dly);
            axi.bvalid  = 1'($urandom);
            n++;
            @(negedge clk);
            if (axi.awready) break;
        end
        axi.awready = 1'($urandom);
        beat = 0; t = 0;
        forever begin
            if (beat == abort) begin
                rst = 1;
                #1;
                chk("rst_awvalid", axi.awvalid, 0);
                chk("rst_wvalid", axi.wvalid, 0);
                chk("rst_wlast", axi.wlast, 0);
                chk("rst_bready", axi.bready, 0);
                chk("rst_done", done_valid, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                @(negedge clk);
                rst = 0; axi.wready = 0; axi.bvalid = 0;
                chk("rst_done_after", done_valid, 0);
                return;
            end
            chk("wvalid", axi.wvalid, 1);
            chk("awvalid_in_w", axi.awvalid, 0);
            chk("bready_in_w", axi.bready, 0);
            chk("done_in_w", done_valid, 0);
            chk("wdata", axi.wdata, sd + DW'(beat));
            chk("wlast", axi.wlast, (beat == int'(l)));
            case (wmode)
                0:       axi.wready = 1;
                1:       axi.wready = (t % 2 == 0);
                default: axi.wready = 1'($urandom);
            endcase
            axi.bvalid = 1'($urandom);
            t++;
            @(negedge clk);
            if (axi.wready) begin
                beat++;
                if (beat > int'(l)) break;
            end
            if (t > 3000) begin bound_fail("w_beats"); return; end
        end
        axi.wready = 0;
        k = 0; tmo = 0;
        forever begin
            chk("bready", axi.bready, 1);
            chk("wvalid_in_b", axi.wvalid, 0);
            chk("done_in_b", done_valid, 0);
            axi.bvalid = (k == b_dly); axi.bid = rbid; axi.bresp = rresp;
            @(negedge clk);
            if (axi.bvalid) break;
            if (TO_EN && k == TO - 1) begin tmo = 1; break; end
            k++;
            if (k > 300) begin bound_fail("b_wait"); axi.bvalid = 0; return; end
        end
        axi.bvalid = 0;
        chk("done_valid", done_valid, 1);
        chk("done_resp", done_resp, tmo ? 2'b10 : rresp);
        chk("done_id_err", done_id_err, tmo ? 1'b0 : (rbid != id));
        chk("bready_after", axi.bready, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        @(negedge clk);
        chk("done_pulse_end", done_valid, 0);
    endtask

    initial begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_wlast", axi.wlast, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_resp", done_resp, 0);
        chk("rst_done_id_err", done_id_err, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_wdata", axi.wdata, 0);
        rst = 0;
        @(negedge clk);

        // basic burst, partner always ready
        burst(32'h1000, 8'd3, 4'd5, 64'h10, 0, 0, 4'd5, 2'b00, 0, -1);
        // single beat behind a 7-cycle AW stall
        burst(32'h2000, 8'd0, 4'd1, 64'hAB, 7, 0, 4'd1, 2'b00, 1, -1);
        // wready toggling
        burst(32'h3000, 8'd7, 4'd2, 64'h100, 1, 1, 4'd2, 2'b01, 2, -1);
        // mismatched bid with DECERR
        burst(32'h4000, 8'd1, 4'd5, 64'h0, 0, 0, 4'd3, 2'b11, 0, -1);
        // reset mid-burst, then a fresh burst from beat 0
        burst(32'h5000, 8'd15, 4'd6, 64'h500, 0, 0, 4'd6, 2'b00, 0, 2);
        burst(32'h6000, 8'd2, 4'd7, 64'h600, 0, 0, 4'd7, 2'b00, 0, -1);
        // 256 beats with data wrap across 2^64
        burst(32'h7000, 8'd255, 4'd8, 64'hFFFF_FFFF_FFFF_FF80, 2, 2, 4'd8, 2'b00, 3, -1);
        // watchdog boundary: bvalid on the last allowed cycle wins
        burst(32'h8000, 8'd1, 4'd9, 64'h9, 0, 0, 4'd9, 2'b01, TO - 1, -1);
        if (TO_EN) burst(32'h9000, 8'd1, 4'd9, 64'h9, 0, 0, 4'd9, 2'b00, 200, -1);

        for (int i = 0; i < 12; i++) begin
            logic [IW-1:0] rid;
            logic [IW-1:0] bidr;
            rid  = IW'($urandom);
            bidr = ($urandom_range(0, 3) == 0) ? IW'($urandom) : rid;
            burst($urandom, 8'($urandom_range(0, 31)), rid, {$urandom, $urandom},
                  $urandom_range(0, 4), 2, bidr, 2'($urandom),
                  $urandom_range(0, TO - 1), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/axi4_wr_burst_gen.md
Name: axi4_wr_burst_gen

Overview:
- Bus-side AXI4 write-master stimulus engine in the DV environment; drives the AW/W channels and consumes B on the same axi4 interface that the protocol assertion checker monitors.
- Accepts one burst command at a time, then sequences it:
  - one AW handshake,
  - awlen+1 W beats with an incrementing data pattern and correct WLAST,
  - one B response, reported on a completion port.
- Holds VALID and payload stable until READY by construction, so every burst it issues is protocol-legal.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; multiple of 8
- ID_W, 4, AWID/BID width
- TO_CYCLES, 1024, B-response watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  ready for a command; high only in IDLE
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  8  AXI awlen (beats-1)
- cmd_id  in  ID_W  transaction ID
- cmd_seed  in  DATA_W  data value of beat 0
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- awaddr  out  ADDR_W  latched cmd_addr
- awlen  out  8  latched cmd_len
- awsize  out  3  log2(DATA_W/8), constant
- awburst  out  2  2'b01 (INCR), constant
- awid  out  ID_W  latched cmd_id
- wvalid  out  1  W valid
- wready  in  1  W ready
- wdata  out  DATA_W  seed + beat index
- wstrb  out  DATA_W/8  all ones
- wlast  out  1  final beat marker
- bvalid  in  1  B valid
- bready  out  1  B ready
- bresp  in  2  write response
- bid  in  ID_W  response ID
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  captured bresp (2'b10 SLVERR on timeout)
- done_id_err  out  1  bid != latched awid at completion

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE.
  - awvalid, wvalid, wlast, bready, done_valid and done_id_err are 0.
  - All latched payload registers, done_resp and the beat counter are 0.
  - Reset mid-burst aborts immediately; no completion pulse is generated.
- FSM states: IDLE, AW, W, B.
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/len/id/seed, clear beat_cnt and go to AW. awvalid rises the next cycle.
  - AW: awvalid=1 with stable payload. On awready, go to W.
  - W:
    - wvalid=1, wdata=seed+beat_cnt (modulo 2^DATA_W), wlast=(beat_cnt==len).
    - Each wvalid&wready increments beat_cnt.
    - The handshake with wlast=1 moves to B.
    - Payload changes only on the cycle after a handshake.
  - B: bready=1. On bvalid, capture bresp and the ID comparison, pulse done_valid for 1 cycle, return to IDLE.
- Outputs are registered.
- AW and W are strictly sequential: no W beat before the AW handshake.
- Back-to-back commands:
  - A new command is accepted in the IDLE cycle after done_valid.
  - Minimum burst-to-burst gap is 1 IDLE cycle.
- Boundary cases:
  - cmd_len=0: single beat, wlast=1 on beat 0.
  - cmd_len=255: 256 beats; beat_cnt is 8 bits and must not wrap before wlast.
  - READY already high when VALID rises: handshake completes in that same cycle.
  - bvalid arriving in a non-B state is ignored; bready stays 0.

Optional Feature:
- Macro: AXI4_WR_TIMEOUT_EN.
- When defined:
  - A counter runs in state B, cleared on entry.
  - If it reaches TO_CYCLES without bvalid, the block:
    - forces done_valid=1 with done_resp=2'b10,
    - sets done_id_err=0,
    - drops bready and returns to IDLE.
  - A bvalid arriving in the same cycle as the timeout wins: normal completion.
- When undefined:
  - No counter is present; the block waits in B indefinitely.
  - TO_CYCLES is unused.

Test Plan:
- cmd addr=0x1000, len=3, id=5, seed=0x10; awready, wready and bready partner always ready -> 1 AW handshake; wdata 0x10..0x13; wlast only on beat 3; bresp=00, bid=5 -> done_valid pulse, done_resp=00, done_id_err=0.
- len=0, awready held low 7 cycles -> awvalid/awaddr stable all 7 cycles; single W beat with wlast=1 after the AW handshake.
- len=7, wready toggling 1,0,1,0 -> wdata/wlast stable while stalled; exactly 8 handshakes; bready asserted only after the last one.
- bid=3 returned for id=5, bresp=2'b11 -> done_resp=11, done_id_err=1; cmd_ready high the following cycle.
- rst asserted during W beat 2 of a len=15 burst -> all valids 0 immediately, no done_valid; a fresh cmd after reset starts at beat 0.
- AXI4_WR_TIMEOUT_EN, TO_CYCLES=16, bvalid never asserted -> done_valid 16 cycles after entering B with done_resp=10; bvalid asserted exactly on cycle 16 -> normal completion with the captured bresp.
